vga_scan: RTL and testbench

Raster scan generator for the hourglass display. Produces the pixel-enable strobe, the `visible_col`/`visible_row` scan coordinates, and the sync/blanking signals. The ball and sand pixel tests consume the coordinates; the VGA connector consumes the sync signals. Because the pixel tests register their result one clock late, the sync and blanking outputs pass through a programmable delay line so they stay aligned with the pixel tests' registered outputs.

---
 rtl/vga_timing_pkg.sv | 15 +
 rtl/sync_delay_line.sv | 20 ++
 rtl/vga_scan.sv | 74 +++++++
 tb/tb_vga_scan.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480 raster timing and the shared coordinate width
package vga_timing_pkg;
  localparam int unsigned DEF_H_VISIBLE = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_VISIBLE = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;
  localparam int unsigned DEF_H_TOTAL   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned DEF_V_TOTAL   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int unsigned CW            = 11;
  typedef logic [CW-1:0] coord_t;
endpackage

// File: rtl/sync_delay_line.sv
// sync_delay_line: DEPTH-stage chain for {video_on, hs_n, vs_n}, reset to blanked/idle
module sync_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] d_i,
  output logic [2:0] q_o
);
  logic [2:0] stg_q [DEPTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stg_q[i] <= 3'b011;
    end else begin
      stg_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stg_q[i] <= stg_q[i-1];
    end
  end
  assign q_o = stg_q[DEPTH-1];
endmodule

// File: rtl/vga_scan.sv
// vga_scan: pixel strobe, raster counters and delayed sync/blank for the hourglass display
module vga_scan
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT    = DEF_H_FRONT,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BACK     = DEF_H_BACK,
  parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT    = DEF_V_FRONT,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BACK     = DEF_V_BACK,
  parameter int unsigned PIX_DIV    = 2,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic          clk,
  input  logic          BTN_S,
  output logic          pix_en,
  output logic [CW-1:0] visible_col,
  output logic [CW-1:0] visible_row,
  output logic          video_on,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start
);
  localparam coord_t H_LAST = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_LAST = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS  = coord_t'(V_VISIBLE);
  localparam coord_t HS_BEG = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_BEG = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
  logic [1:0] div_q, div_d;
  coord_t     col_q, col_d, row_q, row_d;
  logic       fs_q, fs_d, h_end, v_end, active, hs_n, vs_n;
  logic [2:0] dly;
  always_comb begin
    pix_en = div_q == 2'(PIX_DIV - 1);
    h_end  = col_q == H_LAST;
    v_end  = row_q == V_LAST;
    div_d  = pix_en ? 2'd0 : 2'(div_q + 2'd1);
    col_d  = pix_en ? (h_end ? '0 : coord_t'(col_q + 1)) : col_q;
    row_d  = (pix_en && h_end) ? (v_end ? '0 : coord_t'(row_q + 1)) : row_q;
    fs_d   = pix_en && h_end && v_end;
    active = (col_q < H_VIS) && (row_q < V_VIS);
    hs_n   = !((col_q >= HS_BEG) && (col_q < HS_END));
    vs_n   = !((row_q >= VS_BEG) && (row_q < VS_END));
  end
  always_ff @(posedge clk or negedge BTN_S) begin
    if (!BTN_S) begin
      div_q <= '0;
      col_q <= '0;
      row_q <= '0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      col_q <= col_d;
      row_q <= row_d;
      fs_q  <= fs_d;
    end
  end
  // decodes are delayed to line up with the pixel tests' registered outputs
  sync_delay_line #(.DEPTH(SYNC_DELAY)) u_dly (
    .clk   (clk),
    .rst_n (BTN_S),
    .d_i   ({active, hs_n, vs_n}),
    .q_o   (dly)
  );
  assign {video_on, hsync, vsync} = dly;
  assign visible_col = col_q;
  assign visible_row = row_q;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_vga_scan.sv
// tb_vga_scan: directed checks at default timing, a shrunken raster, and PIX_DIV=1/SYNC_DELAY=3
module tb_vga_scan;
  logic clk = 1'b0;
  logic rn0, rn1, rn2;
  logic pe0, vo0, hs0, vs0, fs0;
  logic pe1, vo1, hs1, vs1, fs1;
  logic pe2, vo2, hs2, vs2, fs2;
  logic [10:0] col0, row0, col1, row1, col2, row2;
  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  vga_scan u_def (
    .clk(clk), .BTN_S(rn0), .pix_en(pe0), .visible_col(col0), .visible_row(row0),
    .video_on(vo0), .hsync(hs0), .vsync(vs0), .frame_start(fs0)
  );

  // 15 x 11 raster: frame period 330 clk, hsync cols 10..12, vsync rows 7..8
  vga_scan #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .PIX_DIV(2), .SYNC_DELAY(1)
  ) u_sml (
    .clk(clk), .BTN_S(rn1), .pix_en(pe1), .visible_col(col1), .visible_row(row1),
    .video_on(vo1), .hsync(hs1), .vsync(vs1), .frame_start(fs1)
  );

  vga_scan #(.PIX_DIV(1), .SYNC_DELAY(3)) u_fast (
    .clk(clk), .BTN_S(rn2), .pix_en(pe2), .visible_col(col2), .visible_row(row2),
    .video_on(vo2), .hsync(hs2), .vsync(vs2), .frame_start(fs2)
  );

  task automatic test_reset;
    rn0 = 1'b0; rn1 = 1'b0; rn2 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (col0 !== 11'd0) begin errors++; $display("FAIL reset_col got %0d want 0", col0); end
    checks++; if (row0 !== 11'd0) begin errors++; $display("FAIL reset_row got %0d want 0", row0); end
    checks++; if (pe0 !== 1'b0) begin errors++; $display("FAIL reset_pix_en got %b want 0", pe0); end
    checks++; if (vo0 !== 1'b0) begin errors++; $display("FAIL reset_video_on got %b want 0", vo0); end
    checks++; if (hs0 !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hs0); end
    checks++; if (vs0 !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vs0); end
    checks++; if (fs0 !== 1'b0) begin errors++; $display("FAIL reset_frame_start got %b want 0", fs0); end
    checks++; if (pe2 !== 1'b1) begin errors++; $display("FAIL reset_pix_en_div1 got %b want 1", pe2); end
    @(posedge clk);
    #1 rn0 = 1'b1;
    @(negedge clk);
    cyc = 0;
    checks++; if (vo0 !== 1'b0) begin errors++; $display("FAIL rel_video_on_c0 got %b want 0", vo0); end
    checks++; if (pe0 !== 1'b0) begin errors++; $display("FAIL rel_pix_en_c0 got %b want 0", pe0); end
  endtask

  task automatic test_pix_en;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      cyc = n;
      checks++;
      if (pe0 !== 1'(n % 2)) begin errors++; $display("FAIL pix_en_c%0d got %b want %b", n, pe0, 1'(n % 2)); end
      if (n == 1) begin
        checks++; if (vo0 !== 1'b1) begin errors++; $display("FAIL video_on_rise got %b want 1", vo0); end
      end
      if (n == 2) begin
        checks++; if (col0 !== 11'd1) begin errors++; $display("FAIL col_after_strobe got %0d want 1", col0); end
      end
    end
  endtask

  task automatic test_line;
    int fall, rise, r1599, c1599, r1600, c1600;
    fall = -1; rise = -1; r1599 = -1; c1599 = -1; r1600 = -1; c1600 = -1;
    for (int n = cyc + 1; n <= 1700; n++) begin
      @(negedge clk);
      cyc = n;
      if (fall < 0 && hs0 === 1'b0) fall = n;
      if (fall >= 0 && rise < 0 && hs0 === 1'b1) rise = n;
      if (n == 1599) begin r1599 = int'(row0); c1599 = int'(col0); end
      if (n == 1600) begin r1600 = int'(row0); c1600 = int'(col0); end
    end
    checks++; if (fall != 1313) begin errors++; $display("FAIL hsync_fall got %0d want 1313", fall); end
    checks++; if (rise != 1505) begin errors++; $display("FAIL hsync_rise got %0d want 1505", rise); end
    checks++; if (c1599 != 799) begin errors++; $display("FAIL col_c1599 got %0d want 799", c1599); end
    checks++; if (r1599 != 0) begin errors++; $display("FAIL row_c1599 got %0d want 0", r1599); end
    checks++; if (c1600 != 0) begin errors++; $display("FAIL col_c1600 got %0d want 0", c1600); end
    checks++; if (r1600 != 1) begin errors++; $display("FAIL row_c1600 got %0d want 1", r1600); end
  endtask

  task automatic test_frames;
    int fsn, f1, f2, vlo1, vlo2, vfall, c164, r164, c166;
    logic vo165, vo166, vo167;
    fsn = 0; f1 = -1; f2 = -1; vlo1 = 0; vlo2 = 0; vfall = -1; c164 = -1; r164 = -1; c166 = -1;
    vo165 = 1'bx; vo166 = 1'bx; vo167 = 1'bx;
    @(posedge clk);
    #1 rn1 = 1'b1;
    for (int n = 0; n <= 680; n++) begin
      @(negedge clk);
      if (fs1 === 1'b1) begin
        fsn++;
        if (fsn == 1) f1 = n; else if (fsn == 2) f2 = n;
      end
      if (vs1 === 1'b0) begin
        if (n < 330) vlo1++; else if (n < 660) vlo2++;
        if (vfall < 0) vfall = n;
      end
      if (n == 164) begin c164 = int'(col1); r164 = int'(row1); end
      if (n == 165) vo165 = vo1;
      if (n == 166) begin vo166 = vo1; c166 = int'(col1); end
      if (n == 167) vo167 = vo1;
    end
    checks++; if (fsn != 2) begin errors++; $display("FAIL frame_start_count got %0d want 2", fsn); end
    checks++; if (f1 != 330) begin errors++; $display("FAIL frame_start_1 got %0d want 330", f1); end
    checks++; if (f2 != 660) begin errors++; $display("FAIL frame_start_2 got %0d want 660", f2); end
    checks++; if (vlo1 != 60) begin errors++; $display("FAIL vsync_low_f1 got %0d want 60", vlo1); end
    checks++; if (vlo2 != 60) begin errors++; $display("FAIL vsync_low_f2 got %0d want 60", vlo2); end
    checks++; if (vfall != 211) begin errors++; $display("FAIL vsync_fall got %0d want 211", vfall); end
    checks++; if (c164 != 7 || r164 != 5) begin errors++; $display("FAIL coord_c164 got (%0d,%0d) want (7,5)", c164, r164); end
    checks++; if (c166 != 8) begin errors++; $display("FAIL col_c166 got %0d want 8", c166); end
    checks++; if (vo165 !== 1'b1) begin errors++; $display("FAIL video_on_last_col got %b want 1", vo165); end
    checks++; if (vo166 !== 1'b1) begin errors++; $display("FAIL video_on_last_col2 got %b want 1", vo166); end
    checks++; if (vo167 !== 1'b0) begin errors++; $display("FAIL video_on_first_blank got %b want 0", vo167); end
  endtask

  task automatic test_async_reset;
    int fsn, f1, c2, r30;
    fsn = 0; f1 = -1; c2 = -1; r30 = -1;
    rn1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rn1 = 1'b1;
    for (int n = 0; n <= 263; n++) @(negedge clk);
    checks++; if (hs1 !== 1'b0 || vs1 !== 1'b0) begin errors++; $display("FAIL pre_reset_sync got hs=%b vs=%b want 0 0", hs1, vs1); end
    checks++; if (col1 !== 11'd11 || row1 !== 11'd8) begin errors++; $display("FAIL pre_reset_coord got (%0d,%0d) want (11,8)", col1, row1); end
    #2 rn1 = 1'b0;
    #1;
    checks++; if (col1 !== 11'd0 || row1 !== 11'd0) begin errors++; $display("FAIL async_coord got (%0d,%0d) want (0,0)", col1, row1); end
    checks++; if (hs1 !== 1'b1 || vs1 !== 1'b1) begin errors++; $display("FAIL async_sync got hs=%b vs=%b want 1 1", hs1, vs1); end
    checks++; if (vo1 !== 1'b0 || pe1 !== 1'b0 || fs1 !== 1'b0) begin errors++; $display("FAIL async_flags got vo=%b pe=%b fs=%b want 0 0 0", vo1, pe1, fs1); end
    repeat (3) @(posedge clk);
    #1 rn1 = 1'b1;
    for (int n = 0; n <= 340; n++) begin
      @(negedge clk);
      if (n == 2) c2 = int'(col1);
      if (n == 30) r30 = int'(row1);
      if (fs1 === 1'b1) begin fsn++; if (fsn == 1) f1 = n; end
    end
    checks++; if (c2 != 1) begin errors++; $display("FAIL restart_col got %0d want 1", c2); end
    checks++; if (r30 != 1) begin errors++; $display("FAIL restart_row got %0d want 1", r30); end
    checks++; if (fsn != 1 || f1 != 330) begin errors++; $display("FAIL restart_frame_start got count=%0d at=%0d want 1 at 330", fsn, f1); end
  endtask

  task automatic test_fast;
    int hfall, vrise, vfall, pez, c656;
    hfall = -1; vrise = -1; vfall = -1; pez = 0; c656 = -1;
    @(posedge clk);
    #1 rn2 = 1'b1;
    for (int n = 0; n <= 700; n++) begin
      @(negedge clk);
      if (hfall < 0 && hs2 === 1'b0) hfall = n;
      if (vrise < 0 && vo2 === 1'b1) vrise = n;
      if (vrise >= 0 && vfall < 0 && vo2 === 1'b0) vfall = n;
      if (pe2 !== 1'b1) pez++;
      if (n == 656) c656 = int'(col2);
    end
    checks++; if (vrise != 3) begin errors++; $display("FAIL fast_video_on_rise got %0d want 3", vrise); end
    checks++; if (vfall != 643) begin errors++; $display("FAIL fast_video_on_fall got %0d want 643", vfall); end
    checks++; if (hfall != 659) begin errors++; $display("FAIL fast_hsync_fall got %0d want 659", hfall); end
    checks++; if (c656 != 656) begin errors++; $display("FAIL fast_col_c656 got %0d want 656", c656); end
    checks++; if (pez != 0) begin errors++; $display("FAIL fast_pix_en_low got %0d cycles want 0", pez); end
  endtask

  initial begin
    test_reset;
    test_pix_en;
    test_line;
    test_frames;
    test_async_reset;
    test_fast;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
